// File: rtl/vga_timing.sv
// vga_timing: pixel/line counters and registered timing outputs for a
// 640x480-style VGA raster, plus two line-rate step strobes used by the
// game logic (ball and paddle movement).
//
// Ports
//   vga_clock     pixel clock, all logic on the rising edge
//   reset_n       asynchronous active-low reset
//   vga_hs        horizontal sync, active level SYNC_POL
//   vga_vs        vertical sync, active level SYNC_POL
//   dsp_en        current pixel lies in the visible area
//   vga_x, vga_y  current horizontal / vertical position (also in blanking)
//   end_of_frame  one-clock strobe at the first pixel of vertical blanking
//   clk_ball      one-clock strobe every BALL_DIV lines
//   clk_paddle    one-clock strobe every PADDLE_DIV lines
//
// Every output is registered from the same counter sample, so all outputs
// lag the counters by one clock and stay mutually aligned.

module vga_timing #(
  parameter int H_PIXELS   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_PIXELS   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_POL   = 0,
  parameter int BALL_DIV   = 200,
  parameter int PADDLE_DIV = 100
) (
  input  logic       vga_clock,
  input  logic       reset_n,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       dsp_en,
  output logic [9:0] vga_x,
  output logic [9:0] vga_y,
  output logic       end_of_frame,
  output logic       clk_ball,
  output logic       clk_paddle
);

  localparam int H_TOTAL = H_PIXELS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_PIXELS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_PIXELS);
  localparam logic [9:0] V_VIS    = 10'(V_PIXELS);
  localparam logic [9:0] HS_START = 10'(H_PIXELS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_PIXELS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_PIXELS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_PIXELS + V_FP + V_SYNC);

  localparam logic [11:0] BALL_LAST   = 12'(BALL_DIV - 1);
  localparam logic [11:0] PADDLE_LAST = 12'(PADDLE_DIV - 1);

  localparam logic SYNC_ACT = SYNC_POL[0];

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [11:0] ball_cnt;
  logic [11:0] paddle_cnt;
  logic        line_start;

  assign line_start = (h_cnt == 10'd0);

  // raster counters
  always_ff @(posedge vga_clock or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Line-rate step counters. They free-run across frames; the strobe is
  // registered together with the other outputs so it lines up with vga_x=0.
  always_ff @(posedge vga_clock or negedge reset_n) begin
    if (!reset_n) begin
      ball_cnt   <= '0;
      paddle_cnt <= '0;
      clk_ball   <= 1'b0;
      clk_paddle <= 1'b0;
    end else begin
      clk_ball   <= 1'b0;
      clk_paddle <= 1'b0;
      if (line_start) begin
        if (ball_cnt == BALL_LAST) begin
          ball_cnt <= '0;
          clk_ball <= 1'b1;
        end else begin
          ball_cnt <= ball_cnt + 12'd1;
        end
        if (paddle_cnt == PADDLE_LAST) begin
          paddle_cnt <= '0;
          clk_paddle <= 1'b1;
        end else begin
          paddle_cnt <= paddle_cnt + 12'd1;
        end
      end
    end
  end

  // registered timing outputs, all taken from the same (h_cnt, v_cnt) sample
  always_ff @(posedge vga_clock or negedge reset_n) begin
    if (!reset_n) begin
      vga_x        <= '0;
      vga_y        <= '0;
      dsp_en       <= 1'b0;
      vga_hs       <= ~SYNC_ACT;
      vga_vs       <= ~SYNC_ACT;
      end_of_frame <= 1'b0;
    end else begin
      vga_x        <= h_cnt;
      vga_y        <= v_cnt;
      dsp_en       <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
      vga_hs       <= ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? SYNC_ACT : ~SYNC_ACT;
      vga_vs       <= ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? SYNC_ACT : ~SYNC_ACT;
      end_of_frame <= line_start && (v_cnt == V_VIS);
    end
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter H_PIXELS, default 640: visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16: horizontal front porch, in clocks.
REQ-003 SHALL have parameter H_SYNC, default 96: horizontal sync width, in clocks.
REQ-004 SHALL have parameter H_BP, default 48: horizontal back porch, in clocks.
REQ-005 SHALL have parameter V_PIXELS, default 480: visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10: vertical front porch, in lines.
REQ-007 SHALL have parameter V_SYNC, default 2: vertical sync width, in lines.
REQ-008 SHALL have parameter V_BP, default 33: vertical back porch, in lines.
REQ-009 SHALL have parameter SYNC_POL, default 0: sync active level (0 = active-low).
REQ-010 SHALL have parameter BALL_DIV, default 200: lines per clk_ball strobe, legal range 1..4095.
REQ-011 SHALL have parameter PADDLE_DIV, default 100: lines per clk_paddle strobe, legal range 1..4095.
REQ-012 SHALL have port vga_clock, input, 1 bit: the single 25 MHz pixel clock; all logic rising-edge.
REQ-013 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-014 SHALL have port vga_hs, output, 1 bit: horizontal sync.
REQ-015 SHALL have port vga_vs, output, 1 bit: vertical sync.
REQ-016 SHALL have port dsp_en, output, 1 bit: current pixel is in the visible area.
REQ-017 SHALL have port vga_x, output, 10 bits: horizontal position, 0..H_TOTAL-1.
REQ-018 SHALL have port vga_y, output, 10 bits: vertical position, 0..V_TOTAL-1.
REQ-019 SHALL have port end_of_frame, output, 1 bit: one-clock strobe at the start of vertical blanking.
REQ-020 SHALL have port clk_ball, output, 1 bit: one-clock ball-step strobe.
REQ-021 SHALL have port clk_paddle, output, 1 bit: one-clock paddle-step strobe.

Function
REQ-022 SHALL define H_TOTAL = H_PIXELS+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_PIXELS+V_FP+V_SYNC+V_BP (525).
REQ-023 SHALL increment the horizontal counter every clock, 0..H_TOTAL-1, wrapping to 0.
REQ-024 SHALL increment the vertical counter only on horizontal wrap, 0..V_TOTAL-1, wrapping to 0 when both counters are at their maxima.
REQ-025 SHALL register all outputs, each lagging the counters by exactly one clock and all mutually aligned (same counter sample).
REQ-026 SHALL drive vga_x = h count and vga_y = v count, including during blanking.
REQ-027 SHALL assert dsp_en iff h < H_PIXELS and v < V_PIXELS.
REQ-028 SHALL drive vga_hs = SYNC_POL iff H_PIXELS+H_FP <= h < H_PIXELS+H_FP+H_SYNC, and ~SYNC_POL otherwise.
REQ-029 SHALL drive vga_vs = SYNC_POL iff V_PIXELS+V_FP <= v < V_PIXELS+V_FP+V_SYNC (whole lines), and ~SYNC_POL otherwise.
REQ-030 SHALL pulse end_of_frame for exactly one clock when h==0 and v==V_PIXELS, i.e. once per frame.
REQ-031 SHALL maintain a 12-bit ball line counter, advanced at h==0 of every line; when it reaches BALL_DIV-1 it wraps to 0 and clk_ball pulses for that one clock.
REQ-032 SHALL generate clk_paddle identically to clk_ball from an independent 12-bit counter using PADDLE_DIV.
REQ-033 SHALL, with DIV=1, pulse the corresponding strobe at h==0 of every line.
REQ-034 SHALL keep the strobe counters free-running across frame boundaries, never reset by frame wrap.
REQ-035 SHALL pulse end_of_frame and clk_ball/clk_paddle together in the same clock when they coincide; there is no priority or suppression.

Reset
REQ-036 SHALL, while reset_n=0, immediately and asynchronously clear all counters to 0.
REQ-037 SHALL, while reset_n=0, drive vga_x=0, vga_y=0, dsp_en=0, end_of_frame=0, clk_ball=0, clk_paddle=0, vga_hs=~SYNC_POL and vga_vs=~SYNC_POL.
REQ-038 SHALL, on the first rising edge after reset_n rises, present outputs for h=0, v=0 (dsp_en=1).
REQ-039 SHALL, on reset asserted mid-frame, abandon the frame and restart at (0,0) with no partial strobe.

Verification
REQ-040 Bench SHALL cover: reset release with defaults -> dsp_en=1 and vga_x=0 at 1st edge; dsp_en falls when vga_x=640; vga_x wraps 799->0 with vga_y 0->1.
REQ-041 Bench SHALL cover: default hsync -> vga_hs low for exactly 96 clocks, vga_x 656..751, every line.
REQ-042 Bench SHALL cover: default vsync -> vga_vs low for vga_y 490..491, exactly 1600 clocks; frame period 420000 clocks.
REQ-043 Bench SHALL cover: end_of_frame -> one pulse per 420000 clocks, coincident with vga_x=0, vga_y=480.
REQ-044 Bench SHALL cover: BALL_DIV=3, PADDLE_DIV=1 -> clk_ball every 2400 clocks, clk_paddle every 800 clocks, each one clock wide, both at vga_x=0.
REQ-045 Bench SHALL cover: reset_n pulsed low at vga_y=300 -> outputs immediately at reset values; restart at (0,0); no stray strobe.
